// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port variable-latency memory between the fetch and data requesters.
// One access outstanding at a time, data has priority, and a watchdog aborts unanswered accesses.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err,
    output logic              err_is_data
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDone} state_e;

    localparam logic [7:0] WdogLast = 8'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [7:0]        wdog_q, wdog_d;
    logic              is_data_q, is_data_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic              err_is_data_q, err_is_data_d;

    always_comb begin
        state_d       = state_q;
        wdog_d        = wdog_q;
        is_data_d     = is_data_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        err_d         = 1'b0;
        err_is_data_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                wdog_d = 8'd0;
                if (d_req) begin
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                    mem_we_d    = d_we;
                    is_data_d   = 1'b1;
                    state_d     = StBusyD;
                end else if (i_req) begin
                    mem_addr_d = i_addr;
                    mem_we_d   = 1'b0;
                    mem_be_d   = 4'hF;
                    is_data_d  = 1'b0;
                    state_d    = StBusyI;
                end
            end
            StBusyI, StBusyD: begin
                wdog_d = wdog_q + 8'd1;
                // An ack in the timeout cycle still completes the access normally.
                if (mem_ack) begin
                    if (state_q == StBusyD) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        i_rdata_d = mem_rdata;
                    end
                    state_d = StDone;
                end else if (wdog_q == WdogLast) begin
                    if (state_q == StBusyD) begin
                        d_rdata_d = 32'd0;
                    end else begin
                        i_rdata_d = 32'd0;
                    end
                    err_d         = 1'b1;
                    err_is_data_d = (state_q == StBusyD);
                    state_d       = StDone;
                end
            end
            StDone: begin
                wdog_d  = 8'd0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            wdog_q        <= 8'd0;
            is_data_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= 32'd0;
            mem_be_q      <= 4'd0;
            i_rdata_q     <= 32'd0;
            d_rdata_q     <= 32'd0;
            err_q         <= 1'b0;
            err_is_data_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wdog_q        <= wdog_d;
            is_data_q     <= is_data_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            err_q         <= err_d;
            err_is_data_q <= err_is_data_d;
        end
    end

    always_comb begin
        mem_req     = (state_q == StBusyI) || (state_q == StBusyD);
        mem_we      = mem_we_q;
        mem_addr    = mem_addr_q;
        mem_wdata   = mem_wdata_q;
        mem_be      = mem_be_q;
        i_ready     = (state_q == StDone) && !is_data_q;
        d_ready     = (state_q == StDone) && is_data_q;
        i_rdata     = i_rdata_q;
        d_rdata     = d_rdata_q;
        err         = err_q;
        err_is_data = err_is_data_q;
        stall_if    = i_req & ~i_ready;
        stall_mem   = d_req & ~d_ready;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural memory and request model.
// Directed cases cover latency, priority, store fields, timeout, ack-at-timeout and reset mid-access.
module tb_mem_port_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata = '0;
    logic        stall_if;
    logic        stall_mem;
    logic        err;
    logic        err_is_data;

    logic resp_ack = 1'b0;
    logic extra_ack = 1'b0;
    assign mem_ack = resp_ack | extra_ack;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES(T),
        .ADDR_W        (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_ready    (i_ready),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_be       (d_be),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem),
        .err        (err),
        .err_is_data(err_is_data)
    );

    int n_checks = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        err;
    } exp_t;

    exp_t exp_i[$];
    exp_t exp_d[$];

    // Memory behaviour: ack latency (busy-cycle index of the ack) is a function of the address.
    function automatic int lat_of(input logic [31:0] a);
        case (a)
            32'h100, 32'h104, 32'h2000: return 0;
            32'h2004, 32'h2008:         return 3;
            32'h3000:                   return 15;
            default:                    return int'(a[4:2]);
        endcase
    endfunction

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return {a[15:0], ~a[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: no ready within cycle budget at %0t", name, $time);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_i_ready"}, 32'(i_ready), 0);
        chk({tag, "_d_ready"}, 32'(d_ready), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_err_is_data"}, 32'(err_is_data), 0);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_be"}, 32'(mem_be), 0);
    endtask

    // Callers are at a negedge; cyc counts cycles from the request's first IDLE cycle.
    task automatic do_fetch(input logic [31:0] a, output int cyc);
        exp_t e;
        e.err       = (lat_of(a) >= T);
        e.rdata     = e.err ? 32'd0 : data_of(a);
        e.chk_rdata = 1'b1;
        exp_i.push_back(e);
        i_addr = a;
        i_req  = 1'b1;
        for (cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (i_ready) break;
            chk("stall_if_wait", 32'(stall_if), 1);
        end
        if (cyc > 60) bound_fail("fetch_ready_bound");
        else chk("stall_if_at_ready", 32'(stall_if), 0);
        i_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output int cyc);
        exp_t e;
        e.err       = (lat_of(a) >= T);
        e.rdata     = e.err ? 32'd0 : data_of(a);
        e.chk_rdata = e.err || !we;
        exp_d.push_back(e);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_be    = be;
        d_req   = 1'b1;
        for (cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (d_ready) break;
            chk("stall_mem_wait", 32'(stall_mem), 1);
        end
        if (cyc > 60) bound_fail("data_ready_bound");
        else chk("stall_mem_at_ready", 32'(stall_mem), 0);
        d_req = 1'b0;
    endtask

    // Request levels seen at the most recent rising edge decide who was granted.
    logic last_d = 1'b0;
    always @(posedge clk) last_d <= d_req;

    int          rcnt = 0;
    int          r_lat = 0;
    int          last_len = 0;
    logic        r_is_d;
    logic [31:0] r_addr, r_wdata;
    logic        r_we;
    logic [3:0]  r_be;

    always @(negedge clk) begin
        if (mem_req) begin
            if (rcnt == 0) begin
                r_is_d  = last_d;
                r_addr  = last_d ? d_addr : i_addr;
                r_we    = last_d ? d_we : 1'b0;
                r_wdata = d_wdata;
                r_be    = last_d ? d_be : 4'hF;
                r_lat   = lat_of(r_addr);
            end
            chk("mem_addr", mem_addr, r_addr);
            chk("mem_we", 32'(mem_we), 32'(r_we));
            chk("mem_be", 32'(mem_be), 32'(r_be));
            if (r_is_d) chk("mem_wdata", mem_wdata, r_wdata);
            resp_ack  = (rcnt == r_lat);
            mem_rdata = resp_ack ? data_of(r_addr) : $urandom;
            rcnt++;
        end else begin
            resp_ack = 1'b0;
            if (rcnt > 0) last_len = rcnt;
            rcnt = 0;
        end
    end

    exp_t mon_e;
    always @(negedge clk) begin
        if (i_ready || d_ready) chk("ready_exclusive", 32'(i_ready & d_ready), 0);
        if (err && !(i_ready || d_ready)) chk("err_without_ready", 32'(err), 0);
        if (i_ready) begin
            if (exp_i.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL i_ready_unexpected: got 1 expected 0 at %0t", $time);
            end else begin
                mon_e = exp_i.pop_front();
                chk("i_err", 32'(err), 32'(mon_e.err));
                chk("i_err_is_data", 32'(err_is_data), 0);
                if (mon_e.chk_rdata) chk("i_rdata", i_rdata, mon_e.rdata);
            end
        end
        if (d_ready) begin
            if (exp_d.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL d_ready_unexpected: got 1 expected 0 at %0t", $time);
            end else begin
                mon_e = exp_d.pop_front();
                chk("d_err", 32'(err), 32'(mon_e.err));
                chk("d_err_is_data", 32'(err_is_data), 32'(mon_e.err));
                if (mon_e.chk_rdata) chk("d_rdata", d_rdata, mon_e.rdata);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    int          ci, cd;
    int          rc_i, rc_d;
    logic [31:0] ra_i, ra_d;

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        do_fetch(32'h100, ci);
        chk("fetch_latency", ci, 2);
        repeat (2) @(negedge clk);

        fork
            do_data(1'b0, 32'h2000, 32'h0, 4'hF, cd);
            do_fetch(32'h104, ci);
        join
        chk("simul_data_latency", cd, 2);
        chk("simul_fetch_latency", ci, 5);
        repeat (2) @(negedge clk);

        do_data(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011, cd);
        chk("store_latency", cd, 5);
        repeat (2) @(negedge clk);

        do_data(1'b0, 32'h2008, 32'h0, 4'hF, cd);
        chk("ack_at_timeout_latency", cd, 5);
        repeat (2) @(negedge clk);

        do_data(1'b0, 32'h3000, 32'h0, 4'hF, cd);
        chk("timeout_latency", cd, 5);
        repeat (2) @(negedge clk);
        chk("timeout_mem_req_cycles", last_len, T);

        do_fetch(32'h3000, ci);
        chk("fetch_timeout_latency", ci, 5);
        repeat (2) @(negedge clk);

        i_addr = 32'h3000;
        i_req  = 1'b1;
        repeat (2) @(negedge clk);
        chk("busy_before_reset", 32'(mem_req), 1);
        rst   = 1'b0;
        i_req = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        rst       = 1'b1;
        extra_ack = 1'b1;
        @(negedge clk);
        extra_ack = 1'b0;
        chk("late_ack_i_ready", 32'(i_ready), 0);
        chk("late_ack_d_ready", 32'(d_ready), 0);
        chk("late_ack_i_rdata", i_rdata, 0);
        chk("late_ack_mem_req", 32'(mem_req), 0);
        @(negedge clk);
        do_fetch(32'h100, ci);
        chk("post_reset_fetch_latency", ci, 2);
        repeat (2) @(negedge clk);

        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    ra_i = $urandom & 32'hFFFF_FFFC;
                    if ($urandom_range(0, 5) != 0) ra_i[4] = 1'b0;
                    do_fetch(ra_i, rc_i);
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    ra_d = $urandom & 32'hFFFF_FFFC;
                    if ($urandom_range(0, 5) != 0) ra_d[4] = 1'b0;
                    do_data(1'($urandom_range(0, 1)), ra_d, $urandom,
                            4'($urandom_range(0, 15)), rc_d);
                end
            end
        join
        repeat (4) @(negedge clk);
        chk("exp_i_drained", exp_i.size(), 0);
        chk("exp_d_drained", exp_d.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
